// File: rtl/pi_run_ctrl.sv
// pi_run_ctrl: run controller for the Monte Carlo point-test pipeline.
// Forwards whole (x, y) RNG word pairs into coord_pl, counts returned
// in-circle results, drains outstanding results and reports with a done pulse.
module pi_run_ctrl #(
  parameter int unsigned IP_BIT_WIDTH = 31,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_WIDTH-1:0]    num_samples,
  input  logic [IP_BIT_WIDTH-1:0] rand_num,
  input  logic                    rand_valid,
  output logic [IP_BIT_WIDTH-1:0] coord_rand_num,
  output logic                    coord_rand_valid,
  input  logic                    coord_valid,
  input  logic                    op_lt_1,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [CNT_WIDTH-1:0]    hit_count,
  output logic [CNT_WIDTH-1:0]    total_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] target;
  logic [CNT_WIDTH-1:0] pairs_issued;
  logic [CNT_WIDTH-1:0] total_nxt;
  logic                 half;
  logic                 abort_pend;
  logic                 stop_issue;
  logic                 fwd;
  logic                 res_en;
  logic                 accept;

  // Issue gating: stop only on a pair boundary, so coord_pl never sees half a pair.
  always_comb begin
    accept     = (state == IDLE) && start;
    stop_issue = (state == RUN) && !half && ((pairs_issued == target) || abort_pend);
    fwd        = rand_valid && (state == RUN) && !stop_issue;
    res_en     = coord_valid && ((state == RUN) || (state == DRAIN));
    total_nxt  = total_count + {{(CNT_WIDTH-1){1'b0}}, res_en};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_samples == '0) ? DONE : RUN;
      RUN:     if (stop_issue) state_nxt = DRAIN;
      DRAIN:   if (total_nxt == target) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register plus the zero-latency RNG path.
  always_comb begin
    busy             = (state == RUN) || (state == DRAIN);
    done             = (state == DONE);
    coord_rand_valid = fwd;
    coord_rand_num   = rand_num;
  end

  // Run datapath: pair tracking, abort handling and result counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target       <= '0;
      pairs_issued <= '0;
      half         <= 1'b0;
      abort_pend   <= 1'b0;
      aborted      <= 1'b0;
      hit_count    <= '0;
      total_count  <= '0;
    end else if (accept) begin
      target       <= num_samples;
      pairs_issued <= '0;
      half         <= 1'b0;
      abort_pend   <= 1'b0;
      aborted      <= 1'b0;
      hit_count    <= '0;
      total_count  <= '0;
    end else begin
      if (fwd) begin
        half <= !half;
        if (half) pairs_issued <= pairs_issued + 1'b1;
      end
      abort_pend <= (state == RUN) && !stop_issue && (abort_pend || abort);
      // Abort exit shrinks the target so DRAIN waits only for pairs really issued.
      if (stop_issue && abort_pend) begin
        target  <= pairs_issued;
        aborted <= (pairs_issued != target);
      end
      if (res_en) begin
        total_count <= total_nxt;
        hit_count   <= hit_count + {{(CNT_WIDTH-1){1'b0}}, op_lt_1};
      end
    end
  end

endmodule

// File: tb/tb_pi_run_ctrl.sv
// Directed self-checking bench for pi_run_ctrl with a behavioural coord_pl
// (x/y pairing, 5-cycle latency from y, in-circle test with unit = 2^30).
module tb_pi_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] num_samples;
  logic [30:0] rand_num;
  logic        rand_valid;
  logic [30:0] coord_rand_num;
  logic        coord_rand_valid;
  logic        coord_valid;
  logic        op_lt_1;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] hit_count;
  logic [31:0] total_count;

  int total_checks = 0;
  int bad_checks   = 0;

  pi_run_ctrl #(.IP_BIT_WIDTH(31), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_samples(num_samples), .rand_num(rand_num), .rand_valid(rand_valid),
    .coord_rand_num(coord_rand_num), .coord_rand_valid(coord_rand_valid),
    .coord_valid(coord_valid), .op_lt_1(op_lt_1), .busy(busy), .done(done),
    .aborted(aborted), .hit_count(hit_count), .total_count(total_count)
  );

  always #5 clk = ~clk;

  // coord_pl stand-in
  function automatic logic in_circle(input logic [30:0] x, input logic [30:0] y);
    logic [63:0] s;
    s = 64'(x) * 64'(x) + 64'(y) * 64'(y);
    return s < (64'd1 << 60);
  endfunction

  logic [30:0] xr;
  logic        sel;
  logic [4:0]  vpipe, hpipe;
  logic        push, push_hit;

  always_comb begin
    push     = coord_rand_valid && sel;
    push_hit = push && in_circle(xr, coord_rand_num);
    coord_valid = vpipe[4];
    op_lt_1     = hpipe[4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr <= '0; sel <= 1'b0; vpipe <= '0; hpipe <= '0;
    end else begin
      vpipe <= {vpipe[3:0], push};
      hpipe <= {hpipe[3:0], push_hit};
      if (coord_rand_valid) begin
        sel <= !sel;
        if (!sel) xr <= coord_rand_num;
      end
    end
  end

  // Monitors, sampled on the falling edge.
  int cyc = 0;
  int fwd_words = 0, busy_cycles = 0, done_pulses = 0;
  int last_fwd_cyc = 0, done_cyc = 0;
  logic [31:0] done_hit, done_total;
  logic        done_busy, done_aborted;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (coord_rand_valid) begin fwd_words++; last_fwd_cyc = cyc; end
    if (busy) busy_cycles++;
    if (done) begin
      done_pulses++; done_cyc = cyc;
      done_hit = hit_count; done_total = total_count;
      done_busy = busy; done_aborted = aborted;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input logic [31:0] n);
    rand_valid = 1'b0;
    start = 1'b1; num_samples = n;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; num_samples = 0; rand_num = 0; rand_valid = 1'b1;
    repeat (3) tick();
    total_checks++; if (busy !== 1'b0) begin bad_checks++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total_checks++; if (done !== 1'b0) begin bad_checks++; $display("FAIL reset_done got=%0b want=0", done); end
    total_checks++; if (aborted !== 1'b0) begin bad_checks++; $display("FAIL reset_aborted got=%0b want=0", aborted); end
    total_checks++; if (hit_count !== 32'd0) begin bad_checks++; $display("FAIL reset_hit got=%0d want=0", hit_count); end
    total_checks++; if (total_count !== 32'd0) begin bad_checks++; $display("FAIL reset_total got=%0d want=0", total_count); end
    total_checks++; if (coord_rand_valid !== 1'b0) begin bad_checks++; $display("FAIL reset_crv got=%0b want=0", coord_rand_valid); end
    rand_valid = 1'b0; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int f0, d0;
    start_run(1);
    total_checks++; if (busy !== 1'b1) begin bad_checks++; $display("FAIL single_busy got=%0b want=1", busy); end
    f0 = fwd_words; d0 = done_pulses;
    for (int k = 0; k < 20; k++) begin rand_valid = 1'b1; rand_num = '0; tick(); end
    rand_valid = 1'b0;
    total_checks++; if (fwd_words - f0 !== 2) begin bad_checks++; $display("FAIL single_fwd got=%0d want=2", fwd_words - f0); end
    total_checks++; if (done_pulses - d0 !== 1) begin bad_checks++; $display("FAIL single_done got=%0d want=1", done_pulses - d0); end
    total_checks++; if (done_hit !== 32'd1) begin bad_checks++; $display("FAIL single_hit got=%0d want=1", done_hit); end
    total_checks++; if (done_total !== 32'd1) begin bad_checks++; $display("FAIL single_total got=%0d want=1", done_total); end
    total_checks++; if (done_busy !== 1'b0) begin bad_checks++; $display("FAIL single_busy_at_done got=%0b want=0", done_busy); end
    total_checks++; if (done_cyc - last_fwd_cyc !== 6) begin bad_checks++; $display("FAIL single_latency got=%0d want=6", done_cyc - last_fwd_cyc); end
  endtask

  task automatic test_held_valid();
    logic [30:0] w [6];
    int f0, d0;
    w[0] = 31'h20000000; w[1] = 31'h20000000; w[2] = 31'h40000000;
    w[3] = 31'h0;        w[4] = 31'h0;        w[5] = 31'h0;
    start_run(3);
    f0 = fwd_words; d0 = done_pulses;
    for (int k = 0; k < 25; k++) begin
      rand_valid = 1'b1; rand_num = (k < 6) ? w[k] : 31'h7FFFFFFF; tick();
    end
    rand_valid = 1'b0;
    total_checks++; if (fwd_words - f0 !== 6) begin bad_checks++; $display("FAIL held_fwd got=%0d want=6", fwd_words - f0); end
    total_checks++; if (done_pulses - d0 !== 1) begin bad_checks++; $display("FAIL held_done got=%0d want=1", done_pulses - d0); end
    total_checks++; if (done_hit !== 32'd2) begin bad_checks++; $display("FAIL held_hit got=%0d want=2", done_hit); end
    total_checks++; if (done_total !== 32'd3) begin bad_checks++; $display("FAIL held_total got=%0d want=3", done_total); end
    total_checks++; if (done_aborted !== 1'b0) begin bad_checks++; $display("FAIL held_aborted got=%0b want=0", done_aborted); end
  endtask

  task automatic test_gaps();
    logic [30:0] w [8];
    int f0, d0, idx;
    // pairs: hit, miss, miss, hit
    w[0] = 31'h3FFFFFFF; w[1] = 31'h00000000;
    w[2] = 31'h40000000; w[3] = 31'h00000001;
    w[4] = 31'h30000000; w[5] = 31'h30000000;
    w[6] = 31'h10000000; w[7] = 31'h38000000;
    start_run(4);
    f0 = fwd_words; d0 = done_pulses; idx = 0;
    for (int k = 0; k < 45; k++) begin
      rand_valid = (k % 2 == 0) && !(k >= 5 && k <= 15);
      rand_num   = (idx < 8) ? w[idx] : 31'h0;
      tick();
      if (rand_valid) idx++;
    end
    rand_valid = 1'b0;
    total_checks++; if (fwd_words - f0 !== 8) begin bad_checks++; $display("FAIL gaps_fwd got=%0d want=8", fwd_words - f0); end
    total_checks++; if (done_pulses - d0 !== 1) begin bad_checks++; $display("FAIL gaps_done got=%0d want=1", done_pulses - d0); end
    total_checks++; if (done_hit !== 32'd2) begin bad_checks++; $display("FAIL gaps_hit got=%0d want=2", done_hit); end
    total_checks++; if (done_total !== 32'd4) begin bad_checks++; $display("FAIL gaps_total got=%0d want=4", done_total); end
  endtask

  task automatic test_abort();
    int f0, d0;
    start_run(100);
    f0 = fwd_words; d0 = done_pulses;
    for (int k = 0; k < 30; k++) begin
      rand_valid = 1'b1; rand_num = '0; abort = (k == 11); tick();
    end
    abort = 1'b0; rand_valid = 1'b0;
    total_checks++; if (fwd_words - f0 !== 12) begin bad_checks++; $display("FAIL abort_fwd got=%0d want=12", fwd_words - f0); end
    total_checks++; if (done_pulses - d0 !== 1) begin bad_checks++; $display("FAIL abort_done got=%0d want=1", done_pulses - d0); end
    total_checks++; if (done_total !== 32'd6) begin bad_checks++; $display("FAIL abort_total got=%0d want=6", done_total); end
    total_checks++; if (done_hit !== 32'd6) begin bad_checks++; $display("FAIL abort_hit got=%0d want=6", done_hit); end
    total_checks++; if (aborted !== 1'b1) begin bad_checks++; $display("FAIL abort_flag got=%0b want=1", aborted); end
  endtask

  task automatic test_zero_samples();
    int b0, d0;
    b0 = busy_cycles; d0 = done_pulses;
    start_run(0);
    total_checks++; if (done !== 1'b1) begin bad_checks++; $display("FAIL zero_done got=%0b want=1", done); end
    total_checks++; if (hit_count !== 32'd0) begin bad_checks++; $display("FAIL zero_hit got=%0d want=0", hit_count); end
    total_checks++; if (total_count !== 32'd0) begin bad_checks++; $display("FAIL zero_total got=%0d want=0", total_count); end
    total_checks++; if (aborted !== 1'b0) begin bad_checks++; $display("FAIL zero_aborted got=%0b want=0", aborted); end
    repeat (4) tick();
    total_checks++; if (busy_cycles - b0 !== 0) begin bad_checks++; $display("FAIL zero_busy got=%0d want=0", busy_cycles - b0); end
    total_checks++; if (done_pulses - d0 !== 1) begin bad_checks++; $display("FAIL zero_pulses got=%0d want=1", done_pulses - d0); end
  endtask

  task automatic test_start_during_run();
    int f0, d0;
    start_run(2);
    f0 = fwd_words; d0 = done_pulses;
    for (int k = 0; k < 25; k++) begin
      rand_valid = 1'b1; rand_num = '0;
      start = (k == 2); if (k == 2) num_samples = 32'd5;
      tick();
    end
    start = 1'b0; rand_valid = 1'b0;
    total_checks++; if (fwd_words - f0 !== 4) begin bad_checks++; $display("FAIL restart_fwd got=%0d want=4", fwd_words - f0); end
    total_checks++; if (done_pulses - d0 !== 1) begin bad_checks++; $display("FAIL restart_done got=%0d want=1", done_pulses - d0); end
    total_checks++; if (done_total !== 32'd2) begin bad_checks++; $display("FAIL restart_total got=%0d want=2", done_total); end
  endtask

  task automatic test_reset_mid_run();
    int f0, d0;
    start_run(10);
    for (int k = 0; k < 9; k++) begin rand_valid = 1'b1; rand_num = '0; tick(); end
    total_checks++; if (total_count !== 32'd2) begin bad_checks++; $display("FAIL midrst_pre_total got=%0d want=2", total_count); end
    rst_n = 1'b0; #1;
    total_checks++; if (busy !== 1'b0) begin bad_checks++; $display("FAIL midrst_busy got=%0b want=0", busy); end
    total_checks++; if (total_count !== 32'd0) begin bad_checks++; $display("FAIL midrst_total got=%0d want=0", total_count); end
    total_checks++; if (hit_count !== 32'd0) begin bad_checks++; $display("FAIL midrst_hit got=%0d want=0", hit_count); end
    total_checks++; if (coord_rand_valid !== 1'b0) begin bad_checks++; $display("FAIL midrst_crv got=%0b want=0", coord_rand_valid); end
    tick();
    rand_valid = 1'b0; rst_n = 1'b1;
    tick();
    start_run(2);
    f0 = fwd_words; d0 = done_pulses;
    for (int k = 0; k < 20; k++) begin rand_valid = 1'b1; rand_num = '0; tick(); end
    rand_valid = 1'b0;
    total_checks++; if (fwd_words - f0 !== 4) begin bad_checks++; $display("FAIL postrst_fwd got=%0d want=4", fwd_words - f0); end
    total_checks++; if (done_pulses - d0 !== 1) begin bad_checks++; $display("FAIL postrst_done got=%0d want=1", done_pulses - d0); end
    total_checks++; if (done_hit !== 32'd2) begin bad_checks++; $display("FAIL postrst_hit got=%0d want=2", done_hit); end
    total_checks++; if (done_total !== 32'd2) begin bad_checks++; $display("FAIL postrst_total got=%0d want=2", done_total); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_held_valid();
    test_gaps();
    test_abort();
    test_zero_samples();
    test_start_during_run();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
